e203_ifu_predec_queue: RTL and testbench
========================================

Name: e203_ifu_predec_queue

Overview:
- Parametrised instruction pre-decode queue in the IFU, between the fetch response path and the IR stage.
- Accepts fetched instructions with their PC and mini-decodes them on entry: RV32 or RVC, branch/jump class, jalr rs1 index, branch/jump immediate, and muldiv class.
- Buffers the instruction plus its decoded info in a DEPTH-entry FIFO, so the IFU branch-prediction path sees registered decode info without re-decoding.
- Adds buffering, flush and RVC branch decoding that a pure combinational mini-decoder does not have.

Parameters:
- DEPTH, 2, number of queue entries; power of two, 2..8.
- INSTR_SIZE, 32, instruction width.
- PC_SIZE, 32, PC width.
- XLEN, 32, width of dec_bjp_imm.
- RFIDX_WIDTH, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  discard all entries; highest priority.
- i_valid  in  1  input instruction valid.
- i_ready  out  1  queue can accept.
- i_instr  in  INSTR_SIZE  fetched instruction; bits [15:0] only are meaningful when [1:0]!=2'b11.
- i_pc  in  PC_SIZE  instruction PC.
- o_valid  out  1  head entry valid.
- o_ready  in  1  consumer takes head.
- o_instr  out  INSTR_SIZE  head instruction.
- o_pc  out  PC_SIZE  head PC.
- o_rv32  out  1  head is a 32-bit instruction.
- o_bjp  out  1  head is jal, jalr or bxx.
- o_jal  out  1  head is jal / c.j / c.jal.
- o_jalr  out  1  head is jalr / c.jr / c.jalr.
- o_bxx  out  1  head is a conditional branch (RV32 branch / c.beqz / c.bnez).
- o_jalr_rs1idx  out  RFIDX_WIDTH  jalr base register.
- o_bjp_imm  out  XLEN  sign-extended branch/jump offset.
- o_muldiv  out  6  {mulhsu,mul,div,rem,divu,remu} one-hot or zero.
- o_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst=1): read/write pointers and count 0; o_valid=0; all stored entry fields 0. All head outputs read 0 while empty.
- Input handshake:
  - i_ready = (count<DEPTH) && !flush.
  - Push when i_valid && i_ready.
  - No bypass: a push into an empty queue is visible on o_valid the next cycle (latency 1).
- Output handshake:
  - o_valid = count!=0.
  - Pop when o_valid && o_ready && !flush.
  - Head outputs come straight from the entry registers (no combinational path from i_*).
- Push and pop in the same cycle: count unchanged, both pointers advance.
  - When full, i_ready=0 even if o_ready=1 (no same-cycle refill when full).
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is tracked separately.
- Flush:
  - Pointers and count go to 0 next cycle; entry data is not cleared.
  - Any push or pop in the flush cycle is ignored.
  - rst overrides flush.
- Decode is combinational on i_instr and stored with the entry.
- Class rules:
  - rv32 = instr[1:0]==2'b11.
  - RV32 classes: opcode 1101111 → jal; 1100111 → jalr; 1100011 → bxx; opcode 0110011 with funct7 0000001 → muldiv by funct3 (010 mulhsu, 000 mul, 100 div, 110 rem, 101 divu, 111 remu; 001/011 give 0).
  - RVC classes:
    - c.j (101/01) and c.jal (001/01) → jal.
    - c.jr and c.jalr (100/10 with rs1!=0, rs2==0) → jalr.
    - c.beqz (110/01) and c.bnez (111/01) → bxx.
- jalr_rs1idx: instr[19:15] for RV32 and instr[11:7] for RVC jalr; 0 otherwise.
- bjp_imm, sign-extended to XLEN:
  - J-type for jal.
  - I-type for jalr.
  - B-type for bxx.
  - CJ-format for c.j/c.jal.
  - CB-format for c.beqz/c.bnez.
  - 0 for c.jr/c.jalr and for non-bjp instructions.
- o_bjp = jal|jalr|bxx. The class flags are mutually exclusive.

Decomposition:
- Shared package e203_ifu_pkg:
  - opcode constants (OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_OP), RVC quadrant/funct3 constants.
  - typedef predec_info_t {rv32, jal, jalr, bxx, jalr_rs1idx, bjp_imm, muldiv}.
- One sub-module: e203_ifu_predec_core, purely combinational, instr → predec_info_t. The queue instantiates it on the input side.

Test Plan:
- Reset mid-stream with 2 entries held → next cycle o_valid=0, o_count=0, all head outputs 0, i_ready=1.
- Push 0x008000EF (jal x1,+8) at pc 0x80000000 → one cycle later o_valid=1, o_rv32=1, o_jal=1, o_bjp=1, o_bjp_imm=0x00000008, o_pc=0x80000000.
- Push 0xFE208EE3 (beq x1,x2,-4), then 0x00008067 (jalr x0,0(x1)), with o_ready=0 →
  - first at head: o_bxx=1, o_bjp_imm=0xFFFFFFFC.
  - o_count=2=DEPTH, i_ready=0.
  - after pop: o_jalr=1, o_jalr_rs1idx=1, o_bjp_imm=0.
- Push 0x0000A011 (c.j +4) → o_rv32=0, o_jal=1, o_bjp_imm=0x00000004.
- Push 0x022081B3 (mul x3,x1,x2) → o_muldiv=6'b010000, o_bjp=0; then 0x0220C1B3 (div) → 6'b001000.
- Full queue, assert flush together with i_valid=1 and o_ready=1 → next cycle count=0, o_valid=0, the input is not stored; subsequent pointer wrap over 3·DEPTH push/pop pairs delivers PCs in order.

Source files
------------

// File: rtl/e203_ifu_pkg.sv
// e203_ifu_pkg
// Shared constants and types for the IFU pre-decode path.
//   - RV32 opcode constants used by the mini-decoder.
//   - RVC quadrant / funct3 constants.
//   - predec_info_t: decoded side-band info stored with each queued instruction.
package e203_ifu_pkg;

  localparam int PD_XLEN    = 32;
  localparam int PD_RFIDX_W = 5;

  // RV32 major opcodes
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  // RVC quadrants
  localparam logic [1:0] RVC_Q1 = 2'b01;
  localparam logic [1:0] RVC_Q2 = 2'b10;

  // RVC funct3 values
  localparam logic [2:0] RVC_F3_JAL  = 3'b001;  // c.jal, quadrant 1
  localparam logic [2:0] RVC_F3_J    = 3'b101;  // c.j, quadrant 1
  localparam logic [2:0] RVC_F3_BEQZ = 3'b110;  // c.beqz, quadrant 1
  localparam logic [2:0] RVC_F3_BNEZ = 3'b111;  // c.bnez, quadrant 1
  localparam logic [2:0] RVC_F3_JR   = 3'b100;  // c.jr/c.jalr family, quadrant 2

  typedef struct packed {
    logic                  rv32;
    logic                  jal;
    logic                  jalr;
    logic                  bxx;
    logic [PD_RFIDX_W-1:0] jalr_rs1idx;
    logic [PD_XLEN-1:0]    bjp_imm;
    logic [5:0]            muldiv;  // {mulhsu,mul,div,rem,divu,remu}
  } predec_info_t;

endpackage

// File: rtl/e203_ifu_predec_core.sv
// e203_ifu_predec_core
// Purely combinational mini-decoder: classifies one fetched instruction
// (RV32 or RVC) into jal/jalr/bxx/muldiv and extracts the jalr base register
// and the sign-extended branch/jump offset.
// Ports:
//   instr_i  in  32  fetched instruction (only [15:0] meaningful for RVC)
//   info_o   out     decoded info
module e203_ifu_predec_core
  import e203_ifu_pkg::*;
(
  input  logic [31:0]  instr_i,
  output predec_info_t info_o
);

  logic [6:0]  opc;
  logic [2:0]  f3_32;
  logic [1:0]  quad;
  logic [2:0]  f3_16;
  logic [20:0] imm_j;
  logic [11:0] imm_i;
  logic [12:0] imm_b;
  logic [11:0] imm_cj;
  logic [8:0]  imm_cb;

  assign opc   = instr_i[6:0];
  assign f3_32 = instr_i[14:12];
  assign quad  = instr_i[1:0];
  assign f3_16 = instr_i[15:13];

  assign imm_j  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_i  = instr_i[31:20];
  assign imm_b  = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_cj = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
                   instr_i[2], instr_i[11], instr_i[5:3], 1'b0};
  assign imm_cb = {instr_i[12], instr_i[6:5], instr_i[2], instr_i[11:10],
                   instr_i[4:3], 1'b0};

  always_comb begin
    info_o      = '0;
    info_o.rv32 = (quad == 2'b11);
    if (info_o.rv32) begin
      unique case (opc)
        OPC_JAL: begin
          info_o.jal     = 1'b1;
          info_o.bjp_imm = PD_XLEN'($signed(imm_j));
        end
        OPC_JALR: begin
          info_o.jalr        = 1'b1;
          info_o.jalr_rs1idx = instr_i[19:15];
          info_o.bjp_imm     = PD_XLEN'($signed(imm_i));
        end
        OPC_BRANCH: begin
          info_o.bxx     = 1'b1;
          info_o.bjp_imm = PD_XLEN'($signed(imm_b));
        end
        OPC_OP: begin
          if (instr_i[31:25] == F7_MULDIV) begin
            unique case (f3_32)
              3'b010:  info_o.muldiv = 6'b100000;
              3'b000:  info_o.muldiv = 6'b010000;
              3'b100:  info_o.muldiv = 6'b001000;
              3'b110:  info_o.muldiv = 6'b000100;
              3'b101:  info_o.muldiv = 6'b000010;
              3'b111:  info_o.muldiv = 6'b000001;
              default: info_o.muldiv = 6'b000000;  // mulh / mulhu not tracked
            endcase
          end
        end
        default: ;
      endcase
    end else if (quad == RVC_Q1) begin
      if (f3_16 == RVC_F3_J || f3_16 == RVC_F3_JAL) begin
        info_o.jal     = 1'b1;
        info_o.bjp_imm = PD_XLEN'($signed(imm_cj));
      end else if (f3_16 == RVC_F3_BEQZ || f3_16 == RVC_F3_BNEZ) begin
        info_o.bxx     = 1'b1;
        info_o.bjp_imm = PD_XLEN'($signed(imm_cb));
      end
    end else if (quad == RVC_Q2) begin
      // rs2==0 separates c.jr/c.jalr from c.mv/c.add; rs1!=0 excludes c.ebreak.
      if (f3_16 == RVC_F3_JR && instr_i[11:7] != 5'd0 && instr_i[6:2] == 5'd0) begin
        info_o.jalr        = 1'b1;
        info_o.jalr_rs1idx = instr_i[11:7];
      end
    end
  end

endmodule

// File: rtl/e203_ifu_predec_queue.sv
// e203_ifu_predec_queue
// DEPTH-entry FIFO of fetched instructions plus their pre-decode info.
// Decoding happens on entry so the head outputs are purely registered.
// Ports:
//   clk, rst           clock, async active-high reset
//   flush              drop all entries (beats push/pop)
//   i_valid/i_ready    input handshake; i_instr, i_pc payload
//   o_valid/o_ready    output handshake; o_* head payload and decode info
//   o_count            current occupancy
// Handshake: a transfer happens on a clock edge where valid && ready are both
// high; ready never depends on the same-side valid. i_ready is low while full
// even if the head is being popped, and both readies drop during flush. Head
// outputs read zero whenever the queue is empty.
module e203_ifu_predec_queue
  import e203_ifu_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int INSTR_SIZE  = 32,
  parameter int PC_SIZE     = 32,
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [INSTR_SIZE-1:0]    i_instr,
  input  logic [PC_SIZE-1:0]       i_pc,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [INSTR_SIZE-1:0]    o_instr,
  output logic [PC_SIZE-1:0]       o_pc,
  output logic                     o_rv32,
  output logic                     o_bjp,
  output logic                     o_jal,
  output logic                     o_jalr,
  output logic                     o_bxx,
  output logic [RFIDX_WIDTH-1:0]   o_jalr_rs1idx,
  output logic [XLEN-1:0]          o_bjp_imm,
  output logic [5:0]               o_muldiv,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [INSTR_SIZE-1:0] instr_q [DEPTH];
  logic [PC_SIZE-1:0]    pc_q    [DEPTH];
  predec_info_t          info_q  [DEPTH];

  predec_info_t in_info;
  predec_info_t head_info;
  logic         push, pop;

  e203_ifu_predec_core u_core (
    .instr_i (32'(i_instr)),
    .info_o  (in_info)
  );

  assign i_ready = (count_q < CW'(DEPTH)) && !flush;
  assign o_valid = (count_q != '0);
  assign push    = i_valid && i_ready;
  assign pop     = o_valid && o_ready && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        info_q[i]  <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push) begin
        instr_q[wptr_q] <= i_instr;
        pc_q[wptr_q]    <= i_pc;
        info_q[wptr_q]  <= in_info;
      end
    end
  end

  // Entry data survives a flush, so the head is masked while empty.
  assign head_info     = o_valid ? info_q[rptr_q] : '0;
  assign o_instr       = o_valid ? instr_q[rptr_q] : '0;
  assign o_pc          = o_valid ? pc_q[rptr_q] : '0;
  assign o_rv32        = head_info.rv32;
  assign o_jal         = head_info.jal;
  assign o_jalr        = head_info.jalr;
  assign o_bxx         = head_info.bxx;
  assign o_bjp         = head_info.jal | head_info.jalr | head_info.bxx;
  assign o_jalr_rs1idx = RFIDX_WIDTH'(head_info.jalr_rs1idx);
  assign o_bjp_imm     = XLEN'($signed(head_info.bjp_imm));
  assign o_muldiv      = head_info.muldiv;
  assign o_count       = count_q;

endmodule

// File: tb/tb_e203_ifu_predec_queue.sv
module tb_e203_ifu_predec_queue;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [31:0] i_instr = '0;
  logic [31:0] i_pc = '0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [31:0] o_instr, o_pc, o_bjp_imm;
  logic        o_rv32, o_bjp, o_jal, o_jalr, o_bxx;
  logic [4:0]  o_jalr_rs1idx;
  logic [5:0]  o_muldiv;
  logic [CW-1:0] o_count;

  e203_ifu_predec_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr), .i_pc(i_pc),
    .o_valid(o_valid), .o_ready(o_ready), .o_instr(o_instr), .o_pc(o_pc),
    .o_rv32(o_rv32), .o_bjp(o_bjp), .o_jal(o_jal), .o_jalr(o_jalr), .o_bxx(o_bxx),
    .o_jalr_rs1idx(o_jalr_rs1idx), .o_bjp_imm(o_bjp_imm), .o_muldiv(o_muldiv),
    .o_count(o_count)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];  // {instr, pc}
  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        rv32, jal, jalr, bxx;
    logic [4:0]  rs1;
    logic [31:0] imm;
    logic [5:0]  md;
  } ref_t;

  // Reference decode written directly from the ISA encoding rules.
  function automatic ref_t ref_decode(input logic [31:0] ins);
    ref_t r;
    logic [20:0] j21;
    logic [12:0] b13;
    logic [11:0] c12;
    logic [8:0]  c9;
    r = '0;
    if (ins[1:0] == 2'b11) begin
      r.rv32 = 1'b1;
      if (ins[6:0] == 7'h6F) begin
        r.jal = 1'b1;
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        r.imm = {{11{j21[20]}}, j21};
      end else if (ins[6:0] == 7'h67) begin
        r.jalr = 1'b1;
        r.rs1 = ins[19:15];
        r.imm = {{20{ins[31]}}, ins[31:20]};
      end else if (ins[6:0] == 7'h63) begin
        r.bxx = 1'b1;
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        r.imm = {{19{b13[12]}}, b13};
      end else if (ins[6:0] == 7'h33 && ins[31:25] == 7'h01) begin
        case (ins[14:12])
          3'd2: r.md = 6'b100000;  // mulhsu
          3'd0: r.md = 6'b010000;  // mul
          3'd4: r.md = 6'b001000;  // div
          3'd6: r.md = 6'b000100;  // rem
          3'd5: r.md = 6'b000010;  // divu
          3'd7: r.md = 6'b000001;  // remu
          default: r.md = 6'b0;
        endcase
      end
    end else if (ins[1:0] == 2'b01 && (ins[15:13] == 3'd5 || ins[15:13] == 3'd1)) begin
      r.jal = 1'b1;
      c12 = {ins[12], ins[8], ins[10:9], ins[6], ins[7], ins[2], ins[11], ins[5:3], 1'b0};
      r.imm = {{20{c12[11]}}, c12};
    end else if (ins[1:0] == 2'b01 && ins[15:14] == 2'b11) begin
      r.bxx = 1'b1;
      c9 = {ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0};
      r.imm = {{23{c9[8]}}, c9};
    end else if (ins[1:0] == 2'b10 && ins[15:13] == 3'd4 && ins[11:7] != 0 && ins[6:2] == 0) begin
      r.jalr = 1'b1;
      r.rs1 = ins[11:7];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head();
    logic [63:0] e;
    ref_t r;
    e = '0;
    r = '0;
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      r = ref_decode(e[63:32]);
    end
    check("o_valid", 64'(o_valid), 64'(exp_q.size() != 0));
    check("o_count", 64'(o_count), 64'(exp_q.size()));
    check("o_instr", 64'(o_instr), 64'(e[63:32]));
    check("o_pc", 64'(o_pc), 64'(e[31:0]));
    check("o_rv32", 64'(o_rv32), 64'(r.rv32));
    check("o_jal", 64'(o_jal), 64'(r.jal));
    check("o_jalr", 64'(o_jalr), 64'(r.jalr));
    check("o_bxx", 64'(o_bxx), 64'(r.bxx));
    check("o_bjp", 64'(o_bjp), 64'(r.jal | r.jalr | r.bxx));
    check("o_jalr_rs1idx", 64'(o_jalr_rs1idx), 64'(r.rs1));
    check("o_bjp_imm", 64'(o_bjp_imm), 64'(r.imm));
    check("o_muldiv", 64'(o_muldiv), 64'(r.md));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: check input readiness, advance the model, clock, check the head.
  task automatic tick();
    bit m_ready, do_push, do_pop;
    #2;
    m_ready = (exp_q.size() < DEPTH) && !flush;
    check("i_ready", 64'(i_ready), 64'(m_ready));
    do_push = i_valid && m_ready;
    do_pop  = (exp_q.size() != 0) && o_ready && !flush;
    if (flush) exp_q.delete();
    else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({i_instr, i_pc});
    end
    @(posedge clk);
    #1;
    check_head();
  endtask

  task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
    i_valid = 1'b1; i_instr = ins; i_pc = pc;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic pop1();
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 7))
      0: r[6:0] = 7'h6F;
      1: r[6:0] = 7'h67;
      2: r[6:0] = 7'h63;
      3: begin r[6:0] = 7'h33; r[31:25] = 7'h01; end
      4: r[6:0] = 7'h33;
      5: r[1:0] = 2'b01;
      6: begin r[1:0] = 2'b10; r[15:13] = 3'd4; if ($urandom_range(0, 1) == 1) r[6:2] = '0; end
      default: ;
    endcase
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_head();

    // jal x1,+8
    push1(32'h008000EF, 32'h8000_0000);
    check("jal_flag", 64'(o_jal), 64'd1);
    check("jal_imm", 64'(o_bjp_imm), 64'h8);
    check("jal_pc", 64'(o_pc), 64'h8000_0000);
    pop1();

    // beq then jalr with consumer stalled
    push1(32'hFE208EE3, 32'h8000_0004);
    push1(32'h00008067, 32'h8000_0008);
    check("beq_bxx", 64'(o_bxx), 64'd1);
    check("beq_imm", 64'(o_bjp_imm), 64'hFFFF_FFFC);
    check("full_count", 64'(o_count), 64'(DEPTH));
    o_ready = 1'b1;
    i_valid = 1'b1; i_instr = 32'h1234_5678; i_pc = 32'h9;
    tick();  // full: pop only, no refill
    i_valid = 1'b0; o_ready = 1'b0;
    check("jalr_flag", 64'(o_jalr), 64'd1);
    check("jalr_rs1", 64'(o_jalr_rs1idx), 64'd1);
    check("jalr_imm", 64'(o_bjp_imm), 64'd0);
    pop1();

    // c.j +4, mul, div
    push1(32'h0000A011, 32'h8000_0010);
    check("cj_rv32", 64'(o_rv32), 64'd0);
    check("cj_imm", 64'(o_bjp_imm), 64'h4);
    pop1();
    push1(32'h022081B3, 32'h8000_0012);
    check("mul_md", 64'(o_muldiv), 64'b010000);
    pop1();
    push1(32'h0220C1B3, 32'h8000_0016);
    check("div_md", 64'(o_muldiv), 64'b001000);

    // fill, then flush with push and pop both requested
    push1(32'h0000_0013, 32'h8000_001A);
    flush = 1'b1; i_valid = 1'b1; o_ready = 1'b1; i_instr = 32'h0000_006F; i_pc = 32'hDEAD;
    tick();
    flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0;

    // pointer wrap: 3*DEPTH push/pop pairs
    for (int k = 0; k < 3 * DEPTH + 1; k++) begin
      i_valid = 1'b1; o_ready = 1'b1;
      i_instr = rand_instr(); i_pc = 32'h100 + 32'(4 * k);
      tick();
    end
    i_valid = 1'b0; o_ready = 1'b0;
    pop1();

    // reset mid-stream with two entries held
    push1(32'h008000EF, 32'h2000);
    push1(32'h0000A011, 32'h2004);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check_head();
    check("rst_i_ready", 64'(i_ready), 64'd1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      i_valid = 1'($urandom_range(0, 1));
      o_ready = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 19) == 0);
      i_instr = rand_instr();
      i_pc    = $urandom();
      tick();
    end
    flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0;

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
